// File: rtl/tpu_command_feeder.sv
// -----------------------------------------------------------------------------
// tpu_command_feeder
// Initiator side of the TPU execute/command/busy interface. Bytes arriving on a
// valid/ready stream are assembled into variable-length commands (length taken
// from the opcode byte). Each complete command is parked in a one-deep pending
// buffer and then issued as a single-cycle execute strobe with a 48-bit command
// word. Because the assembler and the pending buffer are separate, the next
// command can be assembled while the TPU is still busy with the current one.
//
// Ports
//   clk_i            system clock
//   reset_i          synchronous, active-high reset
//   rx_valid_i       rx_data_i carries a byte this cycle
//   rx_data_i[7:0]   command byte
//   rx_ready_o       byte is taken when rx_valid_i & rx_ready_o at posedge
//   execute_o        one-cycle command strobe to the TPU
//   command_o[47:0]  command word, held from execute until the next issue
//   busy_i           TPU busy flag
//   error_unknown_o  one-cycle pulse: an unknown opcode byte was dropped
//   error_timeout_o  one-cycle pulse: a partial command was discarded
//
// Parameters
//   ACK_TIMEOUT   cycles after execute to wait for busy before assuming done
//   BYTE_TIMEOUT  idle cycles tolerated mid-command; 0 disables the timeout
// -----------------------------------------------------------------------------

`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT 8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE 8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR 8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK 8'h05
`endif

module tpu_command_feeder #(
   parameter int ACK_TIMEOUT  = 4,
   parameter int BYTE_TIMEOUT = 0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        execute_o,
   output logic [47:0] command_o,
   input  logic        busy_i,
   output logic        error_unknown_o,
   output logic        error_timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_e;

   // Terminal counts; a zero ACK_TIMEOUT degenerates to a single wait cycle.
   localparam logic [15:0] ACK_LAST = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;
   localparam logic [15:0] TO_LAST  = (BYTE_TIMEOUT > 0) ? 16'(BYTE_TIMEOUT - 1) : 16'd0;
   localparam logic        TO_EN    = (BYTE_TIMEOUT > 0);

   // Command length in bytes for an opcode; 0 marks an unknown opcode.
   function automatic logic [2:0] op_len(input logic [7:0] op);
      logic [2:0] len;
      case (op)
         `TPU_CLEARSCREEN: len = 3'd1;
         `TPU_PRINT:       len = 3'd2;
         `TPU_LOCATE:      len = 3'd3;
         `TPU_SETATTR:     len = 3'd3;
         `TPU_SETMASK:     len = 3'd4;
         default:          len = 3'd0;
      endcase
      return len;
   endfunction

   // Issue FSM state
   state_e        state_q, state_d;
   logic [15:0]   ack_cnt_q, ack_cnt_d;

   // Assembler state
   logic [1:0]    idx_q, idx_d;
   logic [2:0]    len_q, len_d;
   logic [31:0]   asm_q, asm_d;
   logic [15:0]   tcnt_q, tcnt_d;

   // Pending buffer
   logic          pend_valid_q, pend_valid_d;
   logic [31:0]   pend_q, pend_d;

   // Registered outputs
   logic          exec_q, exec_d;
   logic [47:0]   cmd_q, cmd_d;
   logic          err_unk_q, err_unk_d;
   logic          err_to_q, err_to_d;

   // Handshake helpers
   logic [2:0]    first_len_s;
   logic          completes_next_s;
   logic          issue_s;
   logic          rx_ready_s;
   logic          accept_s;
   logic          complete_s;
   logic [31:0]   word_s;

   // Byte handshake: the only case that must stall is a completing byte with
   // nowhere to go (pending full and not leaving this cycle).
   always_comb begin
      first_len_s = op_len(rx_data_i);
      if (idx_q == 2'd0) begin
         completes_next_s = (first_len_s == 3'd1);
      end else begin
         completes_next_s = (({1'b0, idx_q} + 3'd1) == len_q);
      end
      issue_s    = (state_q == ST_IDLE) && pend_valid_q && !busy_i;
      rx_ready_s = !(completes_next_s && pend_valid_q && !issue_s);
      accept_s   = rx_valid_i && rx_ready_s;
      complete_s = accept_s && completes_next_s;
      // Byte k lands in bits [8k+7:8k]; a new command starts from a clean word.
      if (idx_q == 2'd0) begin
         word_s = 32'(rx_data_i);
      end else begin
         word_s = asm_q | (32'(rx_data_i) << {idx_q, 3'b000});
      end
   end

   // Assembler, byte timeout and pending-buffer next state.
   always_comb begin
      idx_d        = idx_q;
      len_d        = len_q;
      asm_d        = asm_q;
      tcnt_d       = tcnt_q;
      pend_valid_d = pend_valid_q;
      pend_d       = pend_q;
      err_unk_d    = 1'b0;
      err_to_d     = 1'b0;

      // An arriving byte takes priority over an expiring timeout.
      if (accept_s) begin
         tcnt_d = 16'd0;
         if (idx_q == 2'd0) begin
            if (first_len_s == 3'd0) begin
               err_unk_d = 1'b1;
            end else if (first_len_s == 3'd1) begin
               idx_d = 2'd0;
               asm_d = 32'd0;
            end else begin
               idx_d = 2'd1;
               len_d = first_len_s;
               asm_d = word_s;
            end
         end else if (complete_s) begin
            idx_d = 2'd0;
            asm_d = 32'd0;
         end else begin
            idx_d = idx_q + 2'd1;
            asm_d = word_s;
         end
      end else if (TO_EN && (idx_q != 2'd0) && !rx_valid_i) begin
         if (tcnt_q == TO_LAST) begin
            idx_d    = 2'd0;
            asm_d    = 32'd0;
            tcnt_d   = 16'd0;
            err_to_d = 1'b1;
         end else begin
            tcnt_d = tcnt_q + 16'd1;
         end
      end else begin
         tcnt_d = tcnt_q;
      end

      // A completing byte refills the slot freed by a same-cycle issue.
      if (complete_s) begin
         pend_valid_d = 1'b1;
         pend_d       = word_s;
      end else if (issue_s) begin
         pend_valid_d = 1'b0;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   // Issue FSM state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         ack_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         ack_cnt_q <= ack_cnt_d;
      end
   end

   // Issue FSM next state; ack_cnt counts cycles spent waiting for busy.
   always_comb begin
      state_d   = state_q;
      ack_cnt_d = 16'd0;
      case (state_q)
         ST_IDLE: begin
            if (issue_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (busy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (ack_cnt_q == ACK_LAST) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_WAIT_ACK;
               ack_cnt_d = ack_cnt_q + 16'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (!busy_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Issue FSM outputs: strobe in ISSUE, command captured at the issue edge.
   always_comb begin
      exec_d = (state_d == ST_ISSUE);
      if (issue_s) begin
         cmd_d = {16'h0000, pend_q};
      end else begin
         cmd_d = cmd_q;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         idx_q        <= 2'd0;
         len_q        <= 3'd0;
         asm_q        <= 32'd0;
         tcnt_q       <= 16'd0;
         pend_valid_q <= 1'b0;
         pend_q       <= 32'd0;
         exec_q       <= 1'b0;
         cmd_q        <= 48'd0;
         err_unk_q    <= 1'b0;
         err_to_q     <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         len_q        <= len_d;
         asm_q        <= asm_d;
         tcnt_q       <= tcnt_d;
         pend_valid_q <= pend_valid_d;
         pend_q       <= pend_d;
         exec_q       <= exec_d;
         cmd_q        <= cmd_d;
         err_unk_q    <= err_unk_d;
         err_to_q     <= err_to_d;
      end
   end

   assign rx_ready_o      = rx_ready_s;
   assign execute_o       = exec_q;
   assign command_o       = cmd_q;
   assign error_unknown_o = err_unk_q;
   assign error_timeout_o = err_to_q;

endmodule

// File: tb/tb_tpu_command_feeder.sv
`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT 8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE 8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR 8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK 8'h05
`endif

module tb_tpu_command_feeder;

   localparam int ACK_TO  = 4;
   localparam int BYTE_TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        execute;
   logic [47:0] command;
   logic        busy;
   logic        err_unk;
   logic        err_to;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   tpu_command_feeder #(
      .ACK_TIMEOUT  (ACK_TO),
      .BYTE_TIMEOUT (BYTE_TO)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .rx_valid_i      (rx_valid),
      .rx_data_i       (rx_data),
      .rx_ready_o      (rx_ready),
      .execute_o       (execute),
      .command_o       (command),
      .busy_i          (busy),
      .error_unknown_o (err_unk),
      .error_timeout_o (err_to)
   );

   // TPU model: logs every execute, raises busy one cycle later for tpu_len cycles.
   logic [47:0] exec_cmd [0:63];
   int          exec_cyc [0:63];
   int          exec_n    = 0;
   int          err_unk_n = 0;
   int          err_to_n  = 0;
   int          cyc       = 0;
   int          tpu_len   = 0;

   initial begin : tpu_model
      int left;
      bit arm;
      left = 0;
      arm  = 1'b0;
      busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (left > 0) begin
            left--;
            if (left == 0) busy = 1'b0;
         end
         if (arm) begin
            arm = 1'b0;
            if (tpu_len > 0) begin
               busy = 1'b1;
               left = tpu_len;
            end
         end
         if (execute === 1'b1) begin
            if (exec_n < 64) begin
               exec_cmd[exec_n] = command;
               exec_cyc[exec_n] = cyc;
            end
            exec_n++;
            arm = 1'b1;
         end
         if (err_unk === 1'b1) err_unk_n++;
         if (err_to === 1'b1) err_to_n++;
      end
   end

   // Drive one byte and hold it until accepted; called and returns at posedge+1.
   task automatic send_byte(input logic [7:0] b, output int stalls);
      bit done;
      int n;
      done     = 1'b0;
      stalls   = 0;
      n        = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!done && n < 200) begin
         @(negedge clk);
         if (rx_ready === 1'b1) done = 1'b1;
         else stalls++;
         @(posedge clk);
         #1;
         n++;
      end
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      if (!done) begin
         total_cnt++;
         $display("FAIL send_byte_timeout: byte %0h never accepted, required acceptance within 200 cycles", b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_exec(input int target, input int budget);
      for (int i = 0; i < budget && exec_n < target; i++) begin
         @(posedge clk);
         #1;
      end
      idle(1);
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b expected 1", rx_ready);
      else pass_cnt++;
      total_cnt++;
      if (execute !== 1'b0) $display("FAIL reset_execute: got %b expected 0", execute);
      else pass_cnt++;
      total_cnt++;
      if (command !== 48'h0) $display("FAIL reset_command: got %h expected 0", command);
      else pass_cnt++;
      total_cnt++;
      if ({err_unk, err_to} !== 2'b00) $display("FAIL reset_errors: got %b expected 00", {err_unk, err_to});
      else pass_cnt++;
      reset = 1'b0;
      idle(2);
      total_cnt++;
      if ({rx_ready, execute} !== 2'b10) $display("FAIL reset_release: got %b expected 10", {rx_ready, execute});
      else pass_cnt++;
   endtask

   task automatic test_print();
      int base;
      int s;
      tpu_len = 3;
      base    = exec_n;
      send_byte(`TPU_PRINT, s);
      send_byte(8'h41, s);
      wait_exec(base + 1, 20);
      total_cnt++;
      if (exec_n - base != 1) $display("FAIL print_count: got %0d executes expected 1", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base] !== 48'h0000_0000_4102) $display("FAIL print_command: got %h expected 000000004102", exec_cmd[base]);
      else pass_cnt++;
      idle(10);
      total_cnt++;
      if (exec_n - base != 1) $display("FAIL print_no_repeat: got %0d executes expected 1", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (command !== 48'h0000_0000_4102) $display("FAIL print_hold: got %h expected 000000004102", command);
      else pass_cnt++;
      total_cnt++;
      if (rx_ready !== 1'b1) $display("FAIL print_ready: got %b expected 1", rx_ready);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int base;
      int s;
      int s_last;
      int gap;
      tpu_len = 20;
      base    = exec_n;
      send_byte(`TPU_LOCATE, s);
      send_byte(8'd10, s);
      send_byte(8'd5, s);
      send_byte(`TPU_CLEARSCREEN, s);
      send_byte(`TPU_PRINT, s);
      send_byte(8'h33, s_last);
      wait_exec(base + 3, 200);
      total_cnt++;
      if (exec_n - base != 3) $display("FAIL b2b_count: got %0d executes expected 3", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base] !== 48'h0000_0005_0A03) $display("FAIL b2b_cmd0: got %h expected 000000050a03", exec_cmd[base]);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base+1] !== 48'h0000_0000_0001) $display("FAIL b2b_cmd1: got %h expected 000000000001", exec_cmd[base+1]);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base+2] !== 48'h0000_0000_3302) $display("FAIL b2b_cmd2: got %h expected 000000003302", exec_cmd[base+2]);
      else pass_cnt++;
      total_cnt++;
      if (s_last < 1) $display("FAIL b2b_ready_drop: got %0d stall cycles expected at least 1", s_last);
      else pass_cnt++;
      gap = exec_cyc[base+1] - exec_cyc[base];
      total_cnt++;
      if (gap < 22 || gap > 24) $display("FAIL b2b_spacing: got %0d cycles expected 22..24", gap);
      else pass_cnt++;
      idle(30);
      total_cnt++;
      if (rx_ready !== 1'b1) $display("FAIL b2b_ready_recover: got %b expected 1", rx_ready);
      else pass_cnt++;
   endtask

   task automatic test_setmask();
      int base;
      int s;
      tpu_len = 3;
      base    = exec_n;
      send_byte(`TPU_SETMASK, s);
      send_byte(8'hFF, s);
      send_byte(8'h00, s);
      send_byte(8'hFF, s);
      wait_exec(base + 1, 20);
      total_cnt++;
      if (exec_n - base != 1) $display("FAIL setmask_count: got %0d expected 1", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base][31:8] !== 24'hFF00FF) $display("FAIL setmask_payload: got %h expected ff00ff", exec_cmd[base][31:8]);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base][47:32] !== 16'h0000) $display("FAIL setmask_upper: got %h expected 0000", exec_cmd[base][47:32]);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base][7:0] !== 8'h05) $display("FAIL setmask_opcode: got %h expected 05", exec_cmd[base][7:0]);
      else pass_cnt++;
      idle(10);
   endtask

   task automatic test_unknown();
      int base;
      int ebase;
      int s;
      tpu_len = 3;
      base    = exec_n;
      ebase   = err_unk_n;
      send_byte(8'hEE, s);
      total_cnt++;
      if (err_unk !== 1'b1) $display("FAIL unknown_pulse: got %b expected 1", err_unk);
      else pass_cnt++;
      send_byte(`TPU_PRINT, s);
      send_byte(8'h20, s);
      wait_exec(base + 1, 20);
      idle(8);
      total_cnt++;
      if (err_unk_n - ebase != 1) $display("FAIL unknown_pulse_count: got %0d expected 1", err_unk_n - ebase);
      else pass_cnt++;
      total_cnt++;
      if (exec_n - base != 1) $display("FAIL unknown_exec_count: got %0d expected 1", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base] !== 48'h0000_0000_2002) $display("FAIL unknown_command: got %h expected 000000002002", exec_cmd[base]);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int base;
      int ebase;
      int s;
      int gap;
      tpu_len = 0;
      base    = exec_n;
      ebase   = err_to_n;
      send_byte(`TPU_LOCATE, s);
      send_byte(8'd3, s);
      idle(7);
      total_cnt++;
      if (err_to !== 1'b0) $display("FAIL timeout_early: got %b expected 0 after 7 idle cycles", err_to);
      else pass_cnt++;
      idle(1);
      total_cnt++;
      if (err_to !== 1'b1) $display("FAIL timeout_pulse: got %b expected 1 after 8 idle cycles", err_to);
      else pass_cnt++;
      idle(1);
      total_cnt++;
      if (err_to !== 1'b0) $display("FAIL timeout_single: got %b expected 0", err_to);
      else pass_cnt++;
      total_cnt++;
      if (exec_n != base) $display("FAIL timeout_no_exec: got %0d executes expected 0", exec_n - base);
      else pass_cnt++;
      send_byte(`TPU_CLEARSCREEN, s);
      send_byte(`TPU_PRINT, s);
      send_byte(8'h7A, s);
      wait_exec(base + 2, 100);
      total_cnt++;
      if (exec_cmd[base] !== 48'h0000_0000_0001) $display("FAIL timeout_clear_cmd: got %h expected 000000000001", exec_cmd[base]);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base+1] !== 48'h0000_0000_7A02) $display("FAIL ack_timeout_cmd: got %h expected 000000007a02", exec_cmd[base+1]);
      else pass_cnt++;
      gap = exec_cyc[base+1] - exec_cyc[base];
      total_cnt++;
      if (gap != ACK_TO + 2) $display("FAIL ack_timeout_spacing: got %0d cycles expected %0d", gap, ACK_TO + 2);
      else pass_cnt++;
      total_cnt++;
      if (err_to_n - ebase != 1) $display("FAIL timeout_count: got %0d expected 1", err_to_n - ebase);
      else pass_cnt++;
      idle(10);
   endtask

   task automatic test_reset_mid();
      int base;
      int s;
      tpu_len = 3;
      send_byte(`TPU_SETMASK, s);
      send_byte(8'h01, s);
      send_byte(8'h02, s);
      reset = 1'b1;
      idle(1);
      total_cnt++;
      if ({rx_ready, execute, err_unk, err_to} !== 4'b1000) $display("FAIL rst_asm_flags: got %b expected 1000", {rx_ready, execute, err_unk, err_to});
      else pass_cnt++;
      total_cnt++;
      if (command !== 48'h0) $display("FAIL rst_asm_command: got %h expected 0", command);
      else pass_cnt++;
      reset = 1'b0;
      idle(1);
      base = exec_n;
      send_byte(`TPU_CLEARSCREEN, s);
      wait_exec(base + 1, 20);
      total_cnt++;
      if (exec_n - base != 1) $display("FAIL rst_asm_exec_count: got %0d expected 1", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (exec_cmd[base] !== 48'h0000_0000_0001) $display("FAIL rst_asm_cmd: got %h expected 000000000001", exec_cmd[base]);
      else pass_cnt++;
      idle(10);

      tpu_len = 30;
      base    = exec_n;
      send_byte(`TPU_PRINT, s);
      send_byte(8'h55, s);
      wait_exec(base + 1, 20);
      send_byte(`TPU_CLEARSCREEN, s);
      idle(3);
      reset = 1'b1;
      idle(1);
      total_cnt++;
      if ({rx_ready, execute, err_unk, err_to} !== 4'b1000) $display("FAIL rst_wait_flags: got %b expected 1000", {rx_ready, execute, err_unk, err_to});
      else pass_cnt++;
      total_cnt++;
      if (command !== 48'h0) $display("FAIL rst_wait_command: got %h expected 0", command);
      else pass_cnt++;
      reset = 1'b0;
      base  = exec_n;
      idle(50);
      total_cnt++;
      if (exec_n != base) $display("FAIL rst_wait_no_exec: got %0d executes expected 0", exec_n - base);
      else pass_cnt++;
      total_cnt++;
      if (command !== 48'h0) $display("FAIL rst_wait_cmd_idle: got %h expected 0", command);
      else pass_cnt++;
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_print();
      test_back_to_back();
      test_setmask();
      test_unknown();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
